instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage_pkg.sv | 88 ++++++++
 rtl/instr_decode_stage_decoder_comb.sv | 135 +++++++++++++
 rtl/instr_decode_stage.sv | 133 +++++++++++++
 tb/tb_instr_decode_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// instr_decode_stage_pkg
// Shared decode definitions for the RV32I decode stage and the ALU:
//   - alu_ctrl_e : ALU operation codes
//   - OPC_*      : base opcodes handled by the decoder
//   - F3_* / F7_*: funct3 / funct7 constants (branch conditions included)
//   - dec_t      : decoded control bundle
//   - alu_base_op: funct3 -> ALU op for the non-alternate R/I encodings
// -----------------------------------------------------------------------------
package instr_decode_stage_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLLI = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_SLTU = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SRLI = 5'd9,
        ALU_SRAI = 5'd10,
        ALU_OR   = 5'd11,
        ALU_AND  = 5'd12
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Register fields are kept at architectural width; the stage resizes them.
    typedef struct packed {
        alu_ctrl_e   alu_ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        srcb_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  br_cond;
        logic        illegal;
    } dec_t;

    // Shift entries return the register-shift op; callers patch the imm forms.
    function automatic alu_ctrl_e alu_base_op(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode_stage_decoder_comb.sv
// -----------------------------------------------------------------------------
// instr_decoder_comb
// Purely combinational RV32I subset decoder.
//   instr : raw 32-bit instruction word
//   dec   : decoded control bundle (dec_t)
// Unsupported encodings yield illegal=1 with every strobe cleared and
// alu_ctrl=ADD; register fields are still passed through.
// Non-branch encodings report br_cond=0; R-type reports imm=0.
// -----------------------------------------------------------------------------
module instr_decoder_comb
    import instr_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
    logic        legal;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    always_comb begin
        dec     = '0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        legal   = 1'b1;

        case (opc)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                if (f7 == F7_BASE)
                    dec.alu_ctrl = alu_base_op(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD)
                    dec.alu_ctrl = ALU_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR)
                    dec.alu_ctrl = ALU_SRA;
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.srcb_imm  = 1'b1;
                dec.imm       = imm_i;
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    // Shift-immediates carry a zero-extended shamt, and funct7
                    // selects logical vs arithmetic on the right shift.
                    dec.imm = imm_sh;
                    if (f3 == F3_SLL && f7 == F7_BASE)
                        dec.alu_ctrl = ALU_SLLI;
                    else if (f3 == F3_SR && f7 == F7_BASE)
                        dec.alu_ctrl = ALU_SRLI;
                    else if (f3 == F3_SR && f7 == F7_ALT)
                        dec.alu_ctrl = ALU_SRAI;
                    else
                        legal = 1'b0;
                end else begin
                    dec.alu_ctrl = alu_base_op(f3);
                end
            end
            OPC_LOAD: begin
                if (f3 == F3_LW) begin
                    dec.reg_write = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.srcb_imm  = 1'b1;
                    dec.imm       = imm_i;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_STORE: begin
                if (f3 == F3_SW) begin
                    dec.mem_write = 1'b1;
                    dec.srcb_imm  = 1'b1;
                    dec.imm       = imm_s;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                // funct3 010/011 are holes in the branch space.
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    legal = 1'b0;
                end else begin
                    dec.alu_ctrl = ALU_SUB;
                    dec.branch   = 1'b1;
                    dec.br_cond  = f3;
                    dec.imm      = imm_b;
                end
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.srcb_imm  = 1'b1;
                dec.imm       = imm_j;
            end
            OPC_LUI: begin
                // x0 + imm lets the ALU produce the upper immediate directly.
                dec.rs1       = '0;
                dec.reg_write = 1'b1;
                dec.srcb_imm  = 1'b1;
                dec.imm       = imm_u;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.alu_ctrl  = ALU_ADD;
            dec.imm       = '0;
            dec.srcb_imm  = 1'b0;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.jump      = 1'b0;
            dec.branch    = 1'b0;
            dec.br_cond   = '0;
            dec.illegal   = 1'b1;
        end

        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
// One-register decode stage with valid/ready handshakes on both sides.
//   clk_i, rst_i (sync, active-high), flush_i
//   in_valid_i / in_ready_o / instr_i / pc_i     : fetch side
//   out_valid_o / out_ready_i                    : execute side
//   alu_ctrl_o, rs1_o, rs2_o, rd_o, imm_o, srcb_imm_o, reg_write_o,
//   mem_read_o, mem_write_o, jump_o, branch_o, br_cond_o, pc_o, illegal_o
// Build option DECODE_SKID_BUFFER_EN: adds a one-entry skid buffer so that
// in_ready_o is a flop (!skid_full). Without it in_ready_o is
// out_ready_i || !out_valid_o. With out_ready_i held high both builds behave
// identically.
// -----------------------------------------------------------------------------
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          pc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [4:0]           alu_ctrl_o,
    output logic [RF_ADDR_W-1:0] rs1_o,
    output logic [RF_ADDR_W-1:0] rs2_o,
    output logic [RF_ADDR_W-1:0] rd_o,
    output logic [31:0]          imm_o,
    output logic                 srcb_imm_o,
    output logic                 reg_write_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 jump_o,
    output logic                 branch_o,
    output logic [2:0]           br_cond_o,
    output logic [31:0]          pc_o,
    output logic                 illegal_o
);

    dec_t        dec_new;
    dec_t        out_q;
    logic [31:0] pc_q;
    logic        vld_q;
    logic        accept;

    instr_decoder_comb u_dec (
        .instr (instr_i),
        .dec   (dec_new)
    );

    assign accept = in_valid_i && in_ready_o;

`ifdef DECODE_SKID_BUFFER_EN
    dec_t        skid_q;
    logic [31:0] skid_pc_q;
    logic        skid_full_q;

    assign in_ready_o = !skid_full_q;

    // Skid only fills when the output is stalled, so in_ready_o may lag the
    // stall by a cycle without losing the instruction accepted meanwhile.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q       <= 1'b0;
            out_q       <= '0;
            pc_q        <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
            skid_pc_q   <= '0;
        end else if (flush_i) begin
            vld_q       <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (!vld_q || out_ready_i) begin
            if (skid_full_q) begin
                out_q       <= skid_q;
                pc_q        <= skid_pc_q;
                vld_q       <= 1'b1;
                skid_full_q <= 1'b0;
            end else begin
                vld_q <= accept;
                if (accept) begin
                    out_q <= dec_new;
                    pc_q  <= pc_i;
                end
            end
        end else if (accept) begin
            skid_q      <= dec_new;
            skid_pc_q   <= pc_i;
            skid_full_q <= 1'b1;
        end
    end
`else
    assign in_ready_o = out_ready_i || !vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            out_q <= '0;
            pc_q  <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (in_ready_o) begin
            // Register is empty or being consumed: it takes whatever arrives.
            vld_q <= in_valid_i;
            if (accept) begin
                out_q <= dec_new;
                pc_q  <= pc_i;
            end
        end
    end
`endif

    assign out_valid_o = vld_q;
    assign alu_ctrl_o  = out_q.alu_ctrl;
    assign rs1_o       = RF_ADDR_W'(out_q.rs1);
    assign rs2_o       = RF_ADDR_W'(out_q.rs2);
    assign rd_o        = RF_ADDR_W'(out_q.rd);
    assign imm_o       = out_q.imm;
    assign srcb_imm_o  = out_q.srcb_imm;
    assign reg_write_o = out_q.reg_write;
    assign mem_read_o  = out_q.mem_read;
    assign mem_write_o = out_q.mem_write;
    assign jump_o      = out_q.jump;
    assign branch_o    = out_q.branch;
    assign br_cond_o   = out_q.br_cond;
    assign illegal_o   = out_q.illegal;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_stage
// Random + directed stimulus against a transaction-level model: a queue of
// expected decoded bundles in acceptance order. Each cycle the output must be
// valid exactly when the queue is non-empty and must equal its head; in_ready
// must reflect the occupancy limit of the selected build.
// -----------------------------------------------------------------------------
module tb_instr_decode_stage;

    typedef struct packed {
        logic [4:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        srcb;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        jmp;
        logic        br;
        logic [2:0]  brc;
        logic        ill;
        logic [31:0] pc;
    } bnd_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc;
    logic [4:0]  alu_ctrl, rs1, rs2, rd;
    logic [31:0] imm, pc_out;
    logic        srcb_imm, reg_write, mem_read, mem_write, jump, branch, illegal;
    logic [2:0]  br_cond;

    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    bnd_t q[$];
    bnd_t act;

    always #5 clk = ~clk;

    instr_decode_stage #(.RF_ADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .alu_ctrl_o(alu_ctrl), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .imm_o(imm), .srcb_imm_o(srcb_imm), .reg_write_o(reg_write),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .jump_o(jump),
        .branch_o(branch), .br_cond_o(br_cond), .pc_o(pc_out),
        .illegal_o(illegal)
    );

    assign act = {alu_ctrl, rs1, rs2, rd, imm, srcb_imm, reg_write, mem_read,
                  mem_write, jump, branch, br_cond, illegal, pc_out};

    // Reference decode written from the ISA tables.
    function automatic bnd_t model(input logic [31:0] ins, input logic [31:0] a);
        bnd_t       e, z;
        int         rtab[8];
        logic [6:0] opc, f7;
        logic [2:0] f3;
        bit         ok;
        rtab = '{0, 2, 4, 5, 6, 7, 11, 12}; // add sll slt sltu xor srl or and
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = '0; e.pc = a;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        ok = 1'b1;
        case (opc)
            7'h33: begin
                e.rw = 1'b1;
                if (f7 == 7'h00) e.alu = 5'(rtab[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd8;
                else ok = 1'b0;
            end
            7'h13: begin
                e.rw = 1'b1; e.srcb = 1'b1;
                e.imm = {{20{ins[31]}}, ins[31:20]};
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = {27'b0, ins[24:20]};
                    if (f3 == 3'd1 && f7 == 7'h00) e.alu = 5'd3;
                    else if (f3 == 3'd5 && f7 == 7'h00) e.alu = 5'd9;
                    else if (f3 == 3'd5 && f7 == 7'h20) e.alu = 5'd10;
                    else ok = 1'b0;
                end else e.alu = 5'(rtab[f3]);
            end
            7'h03: if (f3 == 3'd2) begin
                e.rw = 1'b1; e.mr = 1'b1; e.srcb = 1'b1;
                e.imm = {{20{ins[31]}}, ins[31:20]};
            end else ok = 1'b0;
            7'h23: if (f3 == 3'd2) begin
                e.mw = 1'b1; e.srcb = 1'b1;
                e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end else ok = 1'b0;
            7'h63: if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
            else begin
                e.br = 1'b1; e.alu = 5'd1; e.brc = f3;
                e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h6f: begin
                e.jmp = 1'b1; e.rw = 1'b1; e.srcb = 1'b1;
                e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h37: begin
                e.rw = 1'b1; e.srcb = 1'b1; e.rs1 = 5'd0;
                e.imm = {ins[31:12], 12'b0};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            z = '0; z.pc = a; z.rs1 = e.rs1; z.rs2 = e.rs2; z.rd = e.rd; z.ill = 1'b1;
            e = z;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic bit exp_ready();
`ifdef DECODE_SKID_BUFFER_EN
        return q.size() < 2;
`else
        return out_ready || q.size() == 0;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] i, input logic [31:0] p, input logic o);
        @(negedge clk);
        rst = r; flush = f; in_valid = v; instr = i; pc = p; out_ready = o;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs[7];
        logic [6:0] opc, f7;
        logic [4:0] rdf;
        int         k;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h37};
        k = int'($urandom_range(0, 8));
        opc = (k < 7) ? opcs[k] : 7'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        rdf = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), rdf, opc};
    endfunction

    // Model update at the active edge, using the model's own ready.
    always @(posedge clk) begin
        bit rdy;
        rdy = exp_ready();
        if (rst || flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(model(instr, pc));
        end
    end

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check("in_ready", 32'(in_ready), 32'(exp_ready()));
                check("out_valid", 32'(out_valid), 32'(q.size() != 0));
                if (q.size() != 0 && out_valid) begin
                    n_vec++;
                    if (act !== q[0]) begin
                        n_err++;
                        $display("FAIL bundle: got %h expected %h", act, q[0]);
                    end
                end
            end
        end
    end

    initial begin
        bnd_t e;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b0;

        // Pin the model with hand-derived values.
        e = model(32'h40208133, 32'h0);
        check("pin_sub_alu", 32'(e.alu), 32'd1);
        check("pin_sub_rd", 32'(e.rd), 32'd2);
        check("pin_sub_rw", 32'(e.rw), 32'd1);
        e = model(32'h4030D093, 32'h0);
        check("pin_srai_alu", 32'(e.alu), 32'd10);
        check("pin_srai_imm", e.imm, 32'd3);
        e = model(32'hFE209EE3, 32'h0);
        check("pin_bne_imm", e.imm, 32'hFFFFFFFC);
        check("pin_bne_brc", 32'(e.brc), 32'd1);
        e = model(32'h00000000, 32'h0);
        check("pin_zero_ill", 32'(e.ill), 32'd1);

        // Reset state.
        repeat (3) drive(1, 0, 0, 32'h0, 32'h0, 1);
        @(posedge clk); #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imm", imm, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_alu", 32'(alu_ctrl), 32'd0);
        check("rst_strobes", 32'({reg_write, mem_read, mem_write, jump, branch, illegal}), 32'd0);
        chk_en = 1'b1;

        // Directed decodes, one-cycle latency.
        drive(0, 0, 1, 32'h40208133, 32'h100, 1);
        @(posedge clk); #2;
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_alu", 32'(alu_ctrl), 32'd1);
        check("sub_rd", 32'(rd), 32'd2);
        check("sub_rw", 32'(reg_write), 32'd1);
        check("sub_srcb", 32'(srcb_imm), 32'd0);
        drive(0, 0, 1, 32'h4030D093, 32'h104, 1);
        @(posedge clk); #2;
        check("srai_alu", 32'(alu_ctrl), 32'd10);
        check("srai_imm", imm, 32'd3);
        check("srai_srcb", 32'(srcb_imm), 32'd1);
        drive(0, 0, 1, 32'hFE209EE3, 32'h108, 1);
        @(posedge clk); #2;
        check("bne_br", 32'(branch), 32'd1);
        check("bne_brc", 32'(br_cond), 32'd1);
        check("bne_alu", 32'(alu_ctrl), 32'd1);
        check("bne_imm", imm, 32'hFFFFFFFC);
        check("bne_rw", 32'(reg_write), 32'd0);
        check("bne_pc", pc_out, 32'h108);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Three-cycle stall with continuous input, then release.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, rand_instr(), 32'h200 + 32'(4 * i), 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, rand_instr(), 32'h300 + 32'(4 * i), 1);
        repeat (3) drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Flush with valid output and valid input, then an all-zero word.
        drive(0, 0, 1, 32'h40208133, 32'h400, 0);
        drive(0, 1, 1, 32'h4030D093, 32'h404, 0);
        @(posedge clk); #2;
        check("flush_valid", 32'(out_valid), 32'd0);
        drive(0, 0, 1, 32'h00000000, 32'h408, 1);
        @(posedge clk); #2;
        check("zero_valid", 32'(out_valid), 32'd1);
        check("zero_ill", 32'(illegal), 32'd1);
        check("zero_strobes", 32'({reg_write, mem_read, mem_write, jump, branch}), 32'd0);

        // Reset in the middle of traffic.
        drive(0, 0, 1, rand_instr(), 32'h500, 0);
        drive(1, 0, 1, rand_instr(), 32'h504, 0);
        @(posedge clk); #2;
        check("rst_mid_valid", 32'(out_valid), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 9) < 7), rand_instr(), $urandom,
                  ($urandom_range(0, 9) < 6));
        repeat (4) drive(0, 0, 0, 32'h0, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
